// File: rtl/core_sequencer.sv
// Program loader and run sequencer for a small processor core: streams machine code into
// instruction memory, pulses core reset, runs the core and times it. Optional watchdog: SEQ_WATCHDOG_EN.
module core_sequencer #(
  parameter int AW  = 10,
  parameter int IW  = 9,
  parameter int CW  = 16,
  parameter int TMO = 1000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [IW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic          start,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [IW-1:0] imem_wdata,
  output logic          core_reset,
  output logic          core_req,
  input  logic          core_done,
  output logic [AW-1:0] prog_len,
  output logic [CW-1:0] cycles,
  output logic          busy,
  output logic          finished,
  output logic          timed_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LOADED, S_CRST, S_RUN, S_DONE, S_TOUT
  } state_t;

  localparam logic [AW-1:0] ADDR_MAX = '1;
  localparam logic [CW-1:0] CYC_MAX  = '1;

  state_t        state_reg, state_next;
  logic [AW-1:0] addr_reg;
  logic [AW-1:0] len_reg;
  logic [CW-1:0] cyc_reg;
  logic          crst_cnt_reg;

  logic accept, addr_end, load_end, cyc_sat, wd_hit, wd_en;

  assign accept   = ld_valid & ld_ready;
  assign addr_end = (addr_reg == ADDR_MAX);
  // A word landing on the top address closes the program so address 0 is never overwritten.
  assign load_end = accept & (ld_last | addr_end);
  assign cyc_sat  = (cyc_reg == CYC_MAX);
  // True when the RUN cycle in progress is the TMO-th one.
  assign wd_hit   = (64'(cyc_reg) + 64'd1) >= 64'(TMO);

`ifdef SEQ_WATCHDOG_EN
  assign wd_en = 1'b1;
`else
  assign wd_en = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_LOAD: begin
        if (accept) state_next = load_end ? S_LOADED : S_LOAD;
      end
      S_LOADED, S_DONE, S_TOUT: begin
        if (start) state_next = S_CRST;
      end
      S_CRST: begin
        if (crst_cnt_reg) state_next = S_RUN;
      end
      S_RUN: begin
        if (core_done)           state_next = S_DONE;
        else if (wd_en & wd_hit) state_next = S_TOUT;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg     <= '0;
      len_reg      <= '0;
      cyc_reg      <= '0;
      crst_cnt_reg <= 1'b0;
    end else begin
      if (accept && !load_end) addr_reg <= addr_reg + AW'(1);
      // A full memory holds 2^AW words, which prog_len cannot express; it saturates instead.
      if (load_end) len_reg <= addr_end ? ADDR_MAX : addr_reg + AW'(1);
      crst_cnt_reg <= (state_reg == S_CRST) ? ~crst_cnt_reg : 1'b0;
      if (state_next == S_CRST && state_reg != S_CRST) cyc_reg <= '0;
      else if (state_reg == S_RUN && !cyc_sat)         cyc_reg <= cyc_reg + CW'(1);
    end
  end

  always_comb begin
    ld_ready   = (state_reg == S_IDLE) || (state_reg == S_LOAD);
    imem_we    = ld_valid & ld_ready & ~reset;
    core_reset = reset | ~((state_reg == S_RUN) || (state_reg == S_DONE));
    core_req   = ~reset & (state_reg == S_RUN);
    busy       = ~reset & ((state_reg == S_LOAD) || (state_reg == S_CRST) || (state_reg == S_RUN));
    finished   = ~reset & (state_reg == S_DONE);
    timed_out  = wd_en & ~reset & (state_reg == S_TOUT);
  end

  assign imem_addr  = addr_reg;
  assign imem_wdata = ld_data;
  assign prog_len   = len_reg;
  assign cycles     = cyc_reg;

endmodule
